// File: rtl/operand_fetch.sv
// operand_fetch: issue stage that reads the regfile, tracks in-flight destinations and stalls on RAW/WAW.
// Optional build macro OF_FWD_EN bypasses the same-cycle writeback value onto the source operands.
module operand_fetch #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int SC_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_rd_we,
    output logic [REG_AW-1:0] rf_rd_addr_1,
    input  logic [XLEN-1:0]   rf_rd_data_1,
    output logic [REG_AW-1:0] rf_rd_addr_2,
    input  logic [XLEN-1:0]   rf_rd_data_2,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_rs1_data,
    output logic [XLEN-1:0]   out_rs2_data,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_rd_we,
    output logic [SC_W-1:0]   stall_cnt
);
    localparam int NREG = 2**REG_AW;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            fwd_1;
    logic            fwd_2;
    logic            haz_1;
    logic            haz_2;
    logic            haz_rd;
    logic            hazard;
    logic            in_fire;
    logic [XLEN-1:0] opnd_1;
    logic [XLEN-1:0] opnd_2;

    function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
        return (&v) ? v : v + SC_W'(1);
    endfunction

    assign rf_rd_addr_1 = in_rs1;
    assign rf_rd_addr_2 = in_rs2;

`ifdef OF_FWD_EN
    assign fwd_1 = wb_valid && (wb_rd == in_rs1) && (in_rs1 != '0);
    assign fwd_2 = wb_valid && (wb_rd == in_rs2) && (in_rs2 != '0);
`else
    assign fwd_1 = 1'b0;
    assign fwd_2 = 1'b0;
`endif

    // The destination check is never bypassed: only one producer per register may be in flight.
    assign haz_1   = (in_rs1 != '0) && busy[in_rs1] && !fwd_1;
    assign haz_2   = (in_rs2 != '0) && busy[in_rs2] && !fwd_2;
    assign haz_rd  = in_rd_we && (in_rd != '0) && busy[in_rd];
    assign hazard  = haz_1 || haz_2 || haz_rd;

    assign in_ready = reset && !flush && !hazard && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;

    assign opnd_1 = (in_rs1 == '0) ? '0 : (fwd_1 ? wb_data : rf_rd_data_1);
    assign opnd_2 = (in_rs2 == '0) ? '0 : (fwd_2 ? wb_data : rf_rd_data_2);

    // A flushed producer never writes back, so its bit is released here; a new set wins over any clear.
    always_comb begin
        busy_nxt = busy;
        if (wb_valid) busy_nxt[wb_rd] = 1'b0;
        if (flush && out_valid && out_rd_we) busy_nxt[out_rd] = 1'b0;
        if (in_fire && in_rd_we && (in_rd != '0)) busy_nxt[in_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // stage boundary: decode -> execute output register
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            out_rd       <= '0;
            out_rd_we    <= 1'b0;
            busy         <= '0;
            stall_cnt    <= '0;
        end else begin
            busy <= busy_nxt;
            if (in_valid && !flush && hazard) stall_cnt <= sat_inc(stall_cnt);
            if (flush) begin
                out_valid <= 1'b0;
            end else if (in_fire) begin
                out_valid    <= 1'b1;
                out_pc       <= in_pc;
                out_rs1_data <= opnd_1;
                out_rs2_data <= opnd_2;
                out_rd       <= in_rd;
                out_rd_we    <= in_rd_we;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed scenarios plus randomized traffic against a producer-list reference model.
`timescale 1ns/1ps
module tb_operand_fetch;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int SC_W   = 6;
    localparam int NREG   = 2**REG_AW;
    localparam int SAT    = (1 << SC_W) - 1;
`ifdef OF_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [REG_AW-1:0] in_rs1;
    logic [REG_AW-1:0] in_rs2;
    logic [REG_AW-1:0] in_rd;
    logic              in_rd_we;
    logic [REG_AW-1:0] rf_rd_addr_1;
    logic [XLEN-1:0]   rf_rd_data_1;
    logic [REG_AW-1:0] rf_rd_addr_2;
    logic [XLEN-1:0]   rf_rd_data_2;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [XLEN-1:0]   out_rs1_data;
    logic [XLEN-1:0]   out_rs2_data;
    logic [REG_AW-1:0] out_rd;
    logic              out_rd_we;
    logic [SC_W-1:0]   stall_cnt;

    operand_fetch #(.XLEN(XLEN), .REG_AW(REG_AW), .SC_W(SC_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
        .rf_rd_addr_1(rf_rd_addr_1), .rf_rd_data_1(rf_rd_data_1),
        .rf_rd_addr_2(rf_rd_addr_2), .rf_rd_data_2(rf_rd_data_2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic seen_ready;

    // Environment regfile and reference model state.
    logic [XLEN-1:0]   rf     [NREG];
    logic [XLEN-1:0]   m_regs [NREG];
    logic [REG_AW-1:0] exec_q [$];
    logic              m_ov;
    logic [XLEN-1:0]   m_pc, m_d1, m_d2;
    logic [REG_AW-1:0] m_rd;
    logic              m_we;
    int                m_stall;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // A register is busy while its producer sits in the output register or executes downstream.
    function automatic bit m_busy(input logic [REG_AW-1:0] r);
        if (r == '0) return 1'b0;
        if (m_ov && m_we && m_rd == r) return 1'b1;
        foreach (exec_q[i]) if (exec_q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    // Newest architectural value of a source, including this cycle's retirement.
    function automatic logic [XLEN-1:0] src_val(input logic [REG_AW-1:0] s);
        if (s == '0) return '0;
        if (wb_valid && wb_rd == s) return wb_data;
        return m_regs[s];
    endfunction

    task automatic model_eval();
        bit f1, f2, hz, rdy, fire;
        logic [XLEN-1:0] e1, e2;
        seen_ready = in_ready;
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("out_pc", 64'(out_pc), 64'(m_pc));
        chk("out_rs1_data", 64'(out_rs1_data), 64'(m_d1));
        chk("out_rs2_data", 64'(out_rs2_data), 64'(m_d2));
        chk("out_rd", 64'(out_rd), 64'(m_rd));
        chk("out_rd_we", 64'(out_rd_we), 64'(m_we));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        chk("rf_addr_1", 64'(rf_rd_addr_1), 64'(in_rs1));
        chk("rf_addr_2", 64'(rf_rd_addr_2), 64'(in_rs2));
        if (!reset) begin
            chk("in_ready_rst", 64'(in_ready), 64'(0));
            m_ov = 1'b0; m_pc = '0; m_d1 = '0; m_d2 = '0; m_rd = '0; m_we = 1'b0;
            m_stall = 0;
            exec_q.delete();
        end else begin
            f1 = FWD && wb_valid && (wb_rd == in_rs1) && (in_rs1 != '0);
            f2 = FWD && wb_valid && (wb_rd == in_rs2) && (in_rs2 != '0);
            hz = (m_busy(in_rs1) && !f1) || (m_busy(in_rs2) && !f2) || (in_rd_we && m_busy(in_rd));
            rdy = !flush && !hz && (!m_ov || out_ready);
            chk("in_ready", 64'(in_ready), 64'(rdy));
            fire = in_valid && rdy;
            e1 = src_val(in_rs1);
            e2 = src_val(in_rs2);
            if (in_valid && !flush && hz && m_stall < SAT) m_stall++;
            if (wb_valid) begin
                for (int i = 0; i < exec_q.size(); i++)
                    if (exec_q[i] == wb_rd) begin exec_q.delete(i); break; end
            end
            if (flush) begin
                m_ov = 1'b0;
            end else begin
                if (m_ov && out_ready && m_we && m_rd != '0) exec_q.push_back(m_rd);
                if (fire) begin
                    m_ov = 1'b1; m_pc = in_pc; m_d1 = e1; m_d2 = e2; m_rd = in_rd; m_we = in_rd_we;
                end else if (out_ready) begin
                    m_ov = 1'b0;
                end
            end
        end
        if (wb_valid && wb_rd != '0) m_regs[wb_rd] = wb_data;
    endtask

    // Regfile reads on negedge and writes from the writeback port on posedge.
    task automatic step();
        @(negedge clk);
        rf_rd_data_1 = rf[rf_rd_addr_1];
        rf_rd_data_2 = rf[rf_rd_addr_2];
        #1;
        model_eval();
        @(posedge clk);
        if (wb_valid && wb_rd != '0) rf[wb_rd] = wb_data;
        #1;
    endtask

    task automatic issue(input logic [XLEN-1:0] pc, input logic [REG_AW-1:0] rs1,
                         input logic [REG_AW-1:0] rs2, input logic [REG_AW-1:0] rd, input logic we);
        in_valid = 1'b1; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_we = we;
    endtask

    task automatic drive_random();
        int idx;
        if (!(in_valid && !seen_ready)) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_pc    = $urandom;
            in_rs1   = 5'($urandom_range(0, 7));
            in_rs2   = 5'($urandom_range(0, 7));
            in_rd    = 5'($urandom_range(0, 7));
            in_rd_we = 1'($urandom_range(0, 1));
        end
        out_ready = ($urandom_range(0, 9) < 7);
        flush     = ($urandom_range(0, 19) == 0);
        reset     = ($urandom_range(0, 199) != 0);
        if (exec_q.size() != 0 && $urandom_range(0, 9) < 4) begin
            idx = int'($urandom_range(0, exec_q.size() - 1));
            wb_valid = 1'b1;
            wb_rd    = exec_q[idx];
        end else begin
            wb_valid = 1'b0;
            wb_rd    = 5'($urandom_range(0, 31));
        end
        wb_data = $urandom;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_rd_we = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0;
        out_ready = 1'b0; rf_rd_data_1 = '0; rf_rd_data_2 = '0; seen_ready = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            rf[i] = $urandom;
            m_regs[i] = rf[i];
        end
        // x0 must read as zero even from a regfile that returns garbage for it
        rf[0] = 32'hDEAD_BEEF;
        rf[5] = 32'h1234; m_regs[5] = 32'h1234;
        m_ov = 1'b0; m_pc = '0; m_d1 = '0; m_d2 = '0; m_rd = '0; m_we = 1'b0; m_stall = 0;
        @(posedge clk); #1;

        in_valid = 1'b1;
        repeat (3) begin
            step();
            chk("rst_in_ready", 64'(seen_ready), 64'(0));
            chk("rst_out_valid", 64'(out_valid), 64'(0));
            chk("rst_stall_cnt", 64'(stall_cnt), 64'(0));
        end
        reset = 1'b1;

        issue(32'h100, 5'd5, 5'd0, 5'd0, 1'b0); out_ready = 1'b1;
        step();
        chk("x5_valid", 64'(out_valid), 64'(1));
        chk("x5_rs1", 64'(out_rs1_data), 64'h1234);
        chk("x5_rs2", 64'(out_rs2_data), 64'(0));

        issue(32'h200, 5'd0, 5'd0, 5'd7, 1'b1);
        step();
        issue(32'h204, 5'd7, 5'd0, 5'd0, 1'b0);
        repeat (3) step();
        chk("raw_stall_cnt", 64'(stall_cnt), 64'(3));
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hAA;
        step();
        chk("raw_fire_at_wb", 64'(seen_ready), 64'(FWD));
        wb_valid = 1'b0;
        step();
        chk("raw_fire_after_wb", 64'(seen_ready), 64'(1));
        chk("raw_opnd", 64'(out_rs1_data), 64'hAA);
        in_valid = 1'b0;
        step();

        issue(32'h400, 5'd3, 5'd4, 5'd11, 1'b0); out_ready = 1'b1;
        step();
        issue(32'h404, 5'd4, 5'd3, 5'd12, 1'b0); out_ready = 1'b0;
        repeat (4) begin
            step();
            chk("bp_blocked", 64'(seen_ready), 64'(0));
        end
        chk("bp_hold_pc", 64'(out_pc), 64'h400);
        out_ready = 1'b1;
        step();
        chk("bp_accept", 64'(seen_ready), 64'(1));
        chk("bp_new_pc", 64'(out_pc), 64'h404);

        issue(32'h500, 5'd0, 5'd0, 5'd9, 1'b1);
        step();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'(0));
        issue(32'h504, 5'd9, 5'd0, 5'd0, 1'b0); out_ready = 1'b1;
        step();
        chk("flush_no_stall", 64'(seen_ready), 64'(1));

        issue(32'h600, 5'd0, 5'd0, 5'd10, 1'b1);
        step();
        issue(32'h604, 5'd10, 5'd0, 5'd0, 1'b0);
        repeat ((1 << SC_W) + 2) step();
        chk("stall_sat", 64'(stall_cnt), 64'(SAT));
        in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd10; wb_data = $urandom;
        step();
        wb_valid = 1'b0;
        issue(32'h700, 5'd0, 5'd0, 5'd0, 1'b1);
        step();
        issue(32'h704, 5'd0, 5'd0, 5'd0, 1'b1);
        step();
        chk("x0_no_stall", 64'(seen_ready), 64'(1));

        in_valid = 1'b0; reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        repeat (1500) begin
            drive_random();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
